vga_sprite_compositor: RTL and testbench



---
 rtl/vga_sprite_compositor.sv | 145 ++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// Composites N_SPRITES bouncing squares over a background colour, index 0 on top.
// Define VGA_SPRITE_BOUNCE_EN to enable per-frame motion; otherwise sprites stay at reset placement.
module vga_sprite_compositor #(
   parameter int N_SPRITES = 4,
   parameter int RGB_W     = 4,
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SIZE      = 32,
   parameter int SPEED     = 1,
   parameter int INIT_STEP = 48,
   parameter logic [3*RGB_W-1:0] BG_COLOR = 12'h111,
   parameter logic [N_SPRITES*3*RGB_W-1:0] COLORS =
      {12'hFF0, 12'h00F, 12'h0F0, 12'hF00}
) (
   input  logic                 i_clk_100MHz,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_video_on,
   input  logic [9:0]           i_x,
   input  logic [9:0]           i_y,
   output logic [3*RGB_W-1:0]   o_rgb,
   output logic [N_SPRITES-1:0] o_hit,
   output logic                 o_frame,
   output logic                 o_collision
);

   localparam int CW = 3 * RGB_W;

   function automatic logic [9:0] init_x(input int k);
      return 10'(8 + k * INIT_STEP);
   endfunction

   function automatic logic [9:0] init_y(input int k);
      return 10'(8 + (k * INIT_STEP) / 2);
   endfunction

   logic [N_SPRITES-1:0][9:0] sx;
   logic [N_SPRITES-1:0][9:0] sy;
   logic [N_SPRITES-1:0]      hit;
   logic [CW-1:0]             pix;
   logic                      multi;
   logic                      update;
   logic                      ovl;

   assign update = i_tick && (i_x == 10'd0) && (i_y == 10'(V_ACTIVE));

`ifdef VGA_SPRITE_BOUNCE_EN
   logic [N_SPRITES-1:0] dirx;
   logic [N_SPRITES-1:0] diry;

   // Returns {new_dir, new_pos}; overshoot is clamped to the edge.
   function automatic logic [10:0] move(
      input logic [9:0] pos,
      input logic       dir,
      input int         lim
   );
      logic [10:0] ahead;
      ahead = {1'b0, pos} + 11'(SPEED) + 11'(SIZE);
      if (dir) begin
         if (ahead > 11'(lim)) return {1'b0, 10'(lim - SIZE)};
         else return {1'b1, pos + 10'(SPEED)};
      end else begin
         if (pos < 10'(SPEED)) return {1'b1, 10'd0};
         else return {1'b0, pos - 10'(SPEED)};
      end
   endfunction

   always_ff @(posedge i_clk_100MHz) begin
      if (i_reset) begin
         for (int k = 0; k < N_SPRITES; k++) begin
            sx[k]   <= init_x(k);
            sy[k]   <= init_y(k);
            dirx[k] <= (k % 2 == 0);
            diry[k] <= 1'b1;
         end
      end else if (update) begin
         for (int k = 0; k < N_SPRITES; k++) begin
            {dirx[k], sx[k]} <= move(sx[k], dirx[k], H_ACTIVE);
            {diry[k], sy[k]} <= move(sy[k], diry[k], V_ACTIVE);
         end
      end
   end
`else
   always_comb begin
      for (int k = 0; k < N_SPRITES; k++) begin
         sx[k] = init_x(k);
         sy[k] = init_y(k);
      end
   end
`endif

   always_comb begin
      hit = '0;
      for (int k = 0; k < N_SPRITES; k++) begin
         hit[k] = ({1'b0, i_x} >= {1'b0, sx[k]}) &&
                  ({1'b0, i_x} <  {1'b0, sx[k]} + 11'(SIZE)) &&
                  ({1'b0, i_y} >= {1'b0, sy[k]}) &&
                  ({1'b0, i_y} <  {1'b0, sy[k]} + 11'(SIZE));
      end
   end

   // Walk from lowest priority up so the lowest hit index wins.
   always_comb begin
      pix = BG_COLOR;
      for (int k = N_SPRITES - 1; k >= 0; k--) begin
         if (hit[k]) pix = COLORS[k*CW +: CW];
      end
      if (!i_video_on) pix = '0;
   end

   always_comb begin
      logic any;
      any   = 1'b0;
      multi = 1'b0;
      for (int k = 0; k < N_SPRITES; k++) begin
         if (hit[k]) begin
            if (any) multi = 1'b1;
            any = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk_100MHz) begin
      if (i_reset) begin
         o_rgb       <= '0;
         o_hit       <= '0;
         o_frame     <= 1'b0;
         o_collision <= 1'b0;
         ovl         <= 1'b0;
      end else begin
         if (i_tick) begin
            o_rgb <= pix;
            o_hit <= hit;
         end
         o_frame <= update;
         if (update) begin
            o_collision <= ovl;
            ovl         <= 1'b0;
         end else if (i_tick && i_video_on && multi) begin
            ovl <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor with a per-cycle reference model.
// Motion expectations follow VGA_SPRITE_BOUNCE_EN, same as the design build.
module tb_vga_sprite_compositor;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_tick = 1'b0;
   logic        i_video_on = 1'b0;
   logic [9:0]  i_x = '0;
   logic [9:0]  i_y = '0;
   logic [11:0] o_rgb;
   logic [3:0]  o_hit;
   logic        o_frame;
   logic        o_collision;

   always #5 clk = ~clk;

   vga_sprite_compositor dut (
      .i_clk_100MHz(clk),
      .i_reset(i_reset),
      .i_tick(i_tick),
      .i_video_on(i_video_on),
      .i_x(i_x),
      .i_y(i_y),
      .o_rgb(o_rgb),
      .o_hit(o_hit),
      .o_frame(o_frame),
      .o_collision(o_collision)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int n_pulse = 0;
   int n_upd = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference model: sprites as integer rectangles on the screen.
   int          mx[4], my[4];
   bit          mdx[4], mdy[4];
   bit          movl;
   logic [11:0] e_rgb;
   logic [3:0]  e_hit;
   logic        e_frame, e_coll;
   logic [11:0] pal[4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

   always @(posedge clk) begin
      int   cnt;
      bit   upd;
      logic [3:0] cov;
      if (i_reset) begin
         for (int k = 0; k < 4; k++) begin
            mx[k] = 8 + k * 48;
            my[k] = 8 + k * 24;
            mdx[k] = (k % 2 == 0);
            mdy[k] = 1;
         end
         movl = 0;
         e_rgb = 0; e_hit = 0; e_frame = 0; e_coll = 0;
      end else begin
         upd = i_tick && i_x == 0 && i_y == 480;
         e_frame = upd;
         cnt = 0;
         for (int k = 0; k < 4; k++) begin
            cov[k] = (int'(i_x) >= mx[k]) && (int'(i_x) < mx[k] + 32) &&
                     (int'(i_y) >= my[k]) && (int'(i_y) < my[k] + 32);
            if (cov[k]) cnt++;
         end
         if (i_tick) begin
            e_hit = cov;
            e_rgb = 12'h111;
            for (int k = 3; k >= 0; k--) if (cov[k]) e_rgb = pal[k];
            if (!i_video_on) e_rgb = 0;
         end
         if (upd) begin
            e_coll = movl;
            movl = 0;
`ifdef VGA_SPRITE_BOUNCE_EN
            for (int k = 0; k < 4; k++) begin
               if (mdx[k]) begin
                  if (mx[k] + 33 > 640) begin mx[k] = 608; mdx[k] = 0; end
                  else mx[k] = mx[k] + 1;
               end else if (mx[k] < 1) begin mx[k] = 0; mdx[k] = 1; end
               else mx[k] = mx[k] - 1;
               if (mdy[k]) begin
                  if (my[k] + 33 > 480) begin my[k] = 448; mdy[k] = 0; end
                  else my[k] = my[k] + 1;
               end else if (my[k] < 1) begin my[k] = 0; mdy[k] = 1; end
               else my[k] = my[k] - 1;
            end
`endif
         end else if (i_tick && i_video_on && cnt >= 2) begin
            movl = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rgb", o_rgb, e_rgb);
         chk("hit", o_hit, e_hit);
         chk("frame", o_frame, e_frame);
         chk("collision", o_collision, e_coll);
         if (o_frame) n_pulse++;
      end
   end

   task automatic step(input bit t, input bit v, input int x, input int y);
      @(negedge clk);
      i_tick = t;
      i_video_on = v;
      i_x = 10'(x);
      i_y = 10'(y);
      @(posedge clk);
      #1 i_tick = 0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic frame();
      step(1, 1, 8, 8);
      step(1, 1, 47, 44);
      step(1, 1, 140, 70);
      for (int i = 0; i < 3; i++)
         step(1, 1, int'($urandom_range(639)), int'($urandom_range(479)));
      step(1, 0, 0, 480);
      n_upd++;
   endtask

   initial begin
      i_reset = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         i_tick = ~i_tick;
         i_video_on = 1;
         i_x = 10'd8;
         i_y = 10'd8;
      end
      settle();
      chk("rst_rgb", o_rgb, 0);
      chk("rst_hit", o_hit, 0);
      chk("rst_frame", o_frame, 0);
      chk("rst_coll", o_collision, 0);
      @(negedge clk);
      i_reset = 0;
      i_tick = 0;
      chk_en = 1;
      n_pulse = 0;

      step(1, 1, 8, 8);
      settle();
      chk("px88_rgb", o_rgb, 12'hF00);
      chk("px88_hit", o_hit, 4'b0001);
      step(1, 1, 0, 0);
      settle();
      chk("bg_rgb", o_rgb, 12'h111);
      step(1, 0, 8, 8);
      settle();
      chk("blank_rgb", o_rgb, 0);

`ifdef VGA_SPRITE_BOUNCE_EN
      for (int n = 1; n <= 602; n++) begin
         frame();
         settle();
         if (n == 9) begin
            chk("coll_upd9", o_collision, 0);
            step(1, 1, 47, 44);
            settle();
            chk("prio_hit", o_hit, 4'b0011);
            chk("prio_rgb", o_rgb, 12'hF00);
         end
         if (n == 10) chk("coll_upd10", o_collision, 1);
         if (n == 600 || n == 601) begin
            step(1, 1, 608, 300);
            settle();
            chk("edge_in", o_hit[0], 1);
            step(1, 1, 607, 300);
            settle();
            chk("edge_out", o_hit[0], 0);
         end
         if (n == 602) begin
            step(1, 1, 607, 300);
            settle();
            chk("back_in", o_hit[0], 1);
            step(1, 1, 606, 300);
            settle();
            chk("back_out", o_hit[0], 0);
         end
      end
`else
      for (int n = 1; n <= 20; n++) begin
         frame();
         settle();
         chk("static_coll", o_collision, 0);
      end
      step(1, 1, 8, 8);
      settle();
      chk("static_rgb", o_rgb, 12'hF00);
`endif
      step(0, 0, 0, 0);
      settle();
      chk("pulse_count", n_pulse, n_upd);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_cmp, n_fail);
      $finish;
   end

endmodule
